// File: rtl/m_store_buffer.sv
// M-stage store buffer: aligns sb/sh/sw/sd into byte lanes, queues them in a small FIFO,
// merges same-word stores into the youngest entry, drains over valid/ready and forwards to loads.
module m_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [1:0]          req_size,
  output logic                exc_ades,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_byteen,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [ADDR_W-1:0]   fwd_addr,
  output logic [DATA_W/8-1:0] fwd_byteen,
  output logic [DATA_W-1:0]   fwd_data,
  output logic                empty
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(NB - 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [NB-1:0]     be_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, tail_last;
  logic [CW-1:0]     count_q, count_d;
  logic              exc_q;

  logic [OFFW-1:0]   off;
  logic [2:0]        align_mask;
  logic [NB-1:0]     size_mask, req_be;
  logic [DATA_W-1:0] req_shift, req_wd, merge_wd;
  logic [ADDR_W-1:0] req_waddr, fwd_waddr;
  logic              misaligned, accept, push_ok, merge, alloc, pop;
  logic [PW-1:0]     scan_idx;

  assign off = req_addr[OFFW-1:0];

  always_comb begin
    align_mask = 3'd0;
    size_mask  = NB'(1);
    case (req_size)
      2'd0:    begin align_mask = 3'd0; size_mask = NB'(1);  end
      2'd1:    begin align_mask = 3'd1; size_mask = NB'(3);  end
      2'd2:    begin align_mask = 3'd3; size_mask = NB'(15); end
      default: begin align_mask = 3'd7; size_mask = '1;      end
    endcase
  end

  // A dword on a 32-bit bus has no legal placement at all.
  assign misaligned = ((req_size == 2'd3) && (DATA_W == 32)) ||
                      ((off & align_mask[OFFW-1:0]) != '0);
  assign req_be    = size_mask << off;
  assign req_shift = req_data << {off, 3'b000};
  assign req_waddr = req_addr & WORD_MASK;
  assign fwd_waddr = fwd_addr & WORD_MASK;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign req_wd[gi*8 +: 8]   = req_be[gi] ? req_shift[gi*8 +: 8] : 8'h00;
    assign merge_wd[gi*8 +: 8] = req_be[gi] ? req_shift[gi*8 +: 8] : data_q[tail_last][gi*8 +: 8];
  end

  // Merging needs count>=2 so the tail can never be the entry being presented to memory.
  assign accept    = req_valid & req_ready;
  assign push_ok   = accept & ~misaligned;
  assign pop       = mem_valid & mem_ready;
  assign tail_last = tail_q - PW'(1);
  assign merge     = push_ok && (count_q >= CW'(2)) && (addr_q[tail_last] == req_waddr);
  assign alloc     = push_ok & ~merge;
  assign head_d    = pop   ? head_q + PW'(1) : head_q;
  assign tail_d    = alloc ? tail_q + PW'(1) : tail_q;
  assign count_d   = count_q + CW'(alloc) - CW'(pop);

  assign req_ready  = count_q < CW'(DEPTH);
  assign empty      = (count_q == '0);
  assign mem_valid  = ~empty;
  assign mem_addr   = addr_q[head_q];
  assign mem_byteen = be_q[head_q];
  assign mem_wdata  = data_q[head_q];
  assign exc_ades   = exc_q;

  // Walk oldest to youngest so younger stores override overlapping lanes.
  always_comb begin
    fwd_byteen = '0;
    fwd_data   = '0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (vld_q[scan_idx] && (addr_q[scan_idx] == fwd_waddr)) begin
        for (int b = 0; b < NB; b++) begin
          if (be_q[scan_idx][b]) begin
            fwd_byteen[b]      = 1'b1;
            fwd_data[b*8 +: 8] = data_q[scan_idx][b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      vld_q   <= '0;
      exc_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        be_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      exc_q   <= accept & misaligned;
      if (pop) begin
        vld_q[head_q]  <= 1'b0;
        addr_q[head_q] <= '0;
        be_q[head_q]   <= '0;
        data_q[head_q] <= '0;
      end
      if (merge) begin
        be_q[tail_last]   <= be_q[tail_last] | req_be;
        data_q[tail_last] <= merge_wd;
      end
      if (alloc) begin
        vld_q[tail_q]  <= 1'b1;
        addr_q[tail_q] <= req_waddr;
        be_q[tail_q]   <= req_be;
        data_q[tail_q] <= req_wd;
      end
    end
  end
endmodule
